data_bus_arbiter: RTL and testbench

//  Shares the single combinational data_bus (RAM/IO/CSR decode) between two masters:
//  M0 = core load/store unit, M1 = debug/DMA port. Round-robin req/gnt/done handshake.

---
 rtl/data_bus_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter in front of the shared data_bus decode. The winner's request fields are
// latched and held on the bus for HOLD_CYCLES cycles, then read data and exception are captured.
module data_bus_arbiter #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [1:0]  m0_len,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_write,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_read,
  output logic        m0_exc,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [1:0]  m1_len,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_write,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_read,
  output logic        m1_exc,
  output logic        bus_rw,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write,
  input  logic [31:0] bus_read,
  input  logic        bus_exc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        win_r, win_s;          // 1 = M1 owns the current access
  logic        last_m1_r, last_m1_s;  // 1 = M1 was granted last, so M0 wins the next tie
  logic        m0_gnt_r, m0_gnt_s, m1_gnt_r, m1_gnt_s;
  logic        m0_done_r, m0_done_s, m1_done_r, m1_done_s;
  logic [31:0] m0_read_r, m0_read_s, m1_read_r, m1_read_s;
  logic        m0_exc_r, m0_exc_s, m1_exc_r, m1_exc_s;
  logic        bus_rw_r, bus_rw_s;
  logic [1:0]  bus_len_r, bus_len_s;
  logic [31:0] bus_addr_r, bus_addr_s;
  logic [31:0] bus_write_r, bus_write_s;
  logic        grant_s, grant_m1_s;
  logic        sel_rw_s;
  logic [1:0]  sel_len_s;
  logic [31:0] sel_addr_s, sel_write_s;

  // Arbitration decision for the coming edge
  always_comb begin
    grant_s    = 1'b0;
    grant_m1_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_s    = m0_req | m1_req;
        grant_m1_s = m1_req & (~m0_req | (~FIXED_PRIO & ~last_m1_r));
      end
      ST_RESP: begin
        // The finishing master still shows req this cycle, so only the other one may take over.
        grant_s    = win_r ? m0_req : (m1_req & (~FIXED_PRIO | ~m0_req));
        grant_m1_s = ~win_r;
      end
      default: begin
        grant_s    = 1'b0;
        grant_m1_s = 1'b0;
      end
    endcase
  end

  // Request fields of the master about to be granted
  always_comb begin
    sel_rw_s    = grant_m1_s ? m1_rw    : m0_rw;
    sel_len_s   = grant_m1_s ? m1_len   : m0_len;
    sel_addr_s  = grant_m1_s ? m1_addr  : m0_addr;
    sel_write_s = grant_m1_s ? m1_write : m0_write;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    win_s       = win_r;
    last_m1_s   = last_m1_r;
    m0_gnt_s    = m0_gnt_r;
    m1_gnt_s    = m1_gnt_r;
    m0_done_s   = 1'b0;
    m1_done_s   = 1'b0;
    m0_read_s   = m0_read_r;
    m1_read_s   = m1_read_r;
    m0_exc_s    = m0_exc_r;
    m1_exc_s    = m1_exc_r;
    bus_rw_s    = bus_rw_r;
    bus_len_s   = bus_len_r;
    bus_addr_s  = bus_addr_r;
    bus_write_s = bus_write_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        last_m1_s   = (state_r == ST_RESP) ? win_r : last_m1_r;
        state_s     = grant_s ? ST_HOLD : ST_IDLE;
        cnt_s       = 4'd0;
        win_s       = grant_s ? grant_m1_s : win_r;
        m0_gnt_s    = grant_s & ~grant_m1_s;
        m1_gnt_s    = grant_s & grant_m1_s;
        bus_rw_s    = grant_s & sel_rw_s;
        bus_len_s   = grant_s ? sel_len_s   : 2'd0;
        bus_addr_s  = grant_s ? sel_addr_s  : 32'd0;
        bus_write_s = grant_s ? sel_write_s : 32'd0;
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_s     = ST_RESP;
          m0_gnt_s    = 1'b0;
          m1_gnt_s    = 1'b0;
          bus_rw_s    = 1'b0;
          bus_len_s   = 2'd0;
          bus_addr_s  = 32'd0;
          bus_write_s = 32'd0;
          if (win_r) begin
            m1_done_s = 1'b1;
            m1_read_s = bus_read;
            m1_exc_s  = bus_exc;
          end else begin
            m0_done_s = 1'b1;
            m0_read_s = bus_read;
            m0_exc_s  = bus_exc;
          end
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cnt_s       = 4'd0;
        m0_gnt_s    = 1'b0;
        m1_gnt_s    = 1'b0;
        bus_rw_s    = 1'b0;
        bus_len_s   = 2'd0;
        bus_addr_s  = 32'd0;
        bus_write_s = 32'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      win_r       <= 1'b0;
      last_m1_r   <= 1'b1;
      m0_gnt_r    <= 1'b0;
      m1_gnt_r    <= 1'b0;
      m0_done_r   <= 1'b0;
      m1_done_r   <= 1'b0;
      m0_read_r   <= 32'd0;
      m1_read_r   <= 32'd0;
      m0_exc_r    <= 1'b0;
      m1_exc_r    <= 1'b0;
      bus_rw_r    <= 1'b0;
      bus_len_r   <= 2'd0;
      bus_addr_r  <= 32'd0;
      bus_write_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      win_r       <= win_s;
      last_m1_r   <= last_m1_s;
      m0_gnt_r    <= m0_gnt_s;
      m1_gnt_r    <= m1_gnt_s;
      m0_done_r   <= m0_done_s;
      m1_done_r   <= m1_done_s;
      m0_read_r   <= m0_read_s;
      m1_read_r   <= m1_read_s;
      m0_exc_r    <= m0_exc_s;
      m1_exc_r    <= m1_exc_s;
      bus_rw_r    <= bus_rw_s;
      bus_len_r   <= bus_len_s;
      bus_addr_r  <= bus_addr_s;
      bus_write_r <= bus_write_s;
    end
  end

  assign m0_gnt    = m0_gnt_r;
  assign m0_done   = m0_done_r;
  assign m0_read   = m0_read_r;
  assign m0_exc    = m0_exc_r;
  assign m1_gnt    = m1_gnt_r;
  assign m1_done   = m1_done_r;
  assign m1_read   = m1_read_r;
  assign m1_exc    = m1_exc_r;
  assign bus_rw    = bus_rw_r;
  assign bus_len   = bus_len_r;
  assign bus_addr  = bus_addr_r;
  assign bus_write = bus_write_r;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model of grant order, hold timing and captured responses.
module tb_data_bus_arbiter;

  localparam int          H     = 2;
  localparam logic [31:0] MAGIC = 32'hDEAD_AEEF;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [2];
  logic        rw    [2];
  logic [1:0]  len   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic        m0_gnt, m0_done, m0_exc, m1_gnt, m1_done, m1_exc, bus_rw, bus_exc;
  logic [31:0] m0_read, m1_read, bus_addr, bus_write, bus_read;
  logic [1:0]  bus_len;
  logic        fp_m0_gnt, fp_m0_done, fp_m0_exc, fp_m1_gnt, fp_m1_done, fp_m1_exc, fp_bus_rw, fp_bus_exc;
  logic [31:0] fp_m0_read, fp_m1_read, fp_bus_addr, fp_bus_write, fp_bus_read;
  logic [1:0]  fp_bus_len;

  // data_bus stand-in: read data and exception are pure functions of the address
  assign bus_read    = bus_addr ^ MAGIC;
  assign bus_exc     = bus_addr[31] & bus_addr[0];
  assign fp_bus_read = fp_bus_addr ^ MAGIC;
  assign fp_bus_exc  = fp_bus_addr[31] & fp_bus_addr[0];

  always #5 clk = ~clk;

  data_bus_arbiter #(.HOLD_CYCLES(H), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_rw(rw[0]), .m0_len(len[0]), .m0_addr(addr[0]), .m0_write(wdata[0]),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_read(m0_read), .m0_exc(m0_exc),
    .m1_req(req[1]), .m1_rw(rw[1]), .m1_len(len[1]), .m1_addr(addr[1]), .m1_write(wdata[1]),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_read(m1_read), .m1_exc(m1_exc),
    .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_read(bus_read), .bus_exc(bus_exc)
  );

  data_bus_arbiter #(.HOLD_CYCLES(H), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_rw(rw[0]), .m0_len(len[0]), .m0_addr(addr[0]), .m0_write(wdata[0]),
    .m0_gnt(fp_m0_gnt), .m0_done(fp_m0_done), .m0_read(fp_m0_read), .m0_exc(fp_m0_exc),
    .m1_req(req[1]), .m1_rw(rw[1]), .m1_len(len[1]), .m1_addr(addr[1]), .m1_write(wdata[1]),
    .m1_gnt(fp_m1_gnt), .m1_done(fp_m1_done), .m1_read(fp_m1_read), .m1_exc(fp_m1_exc),
    .bus_rw(fp_bus_rw), .bus_len(fp_bus_len), .bus_addr(fp_bus_addr), .bus_write(fp_bus_write),
    .bus_read(fp_bus_read), .bus_exc(fp_bus_exc)
  );

  // Reference model: an access granted at edge g holds the bus until edge g+H, where it completes.
  int          owner, grant_edge, edge_no, just_done, last;
  logic        e_gnt [2];
  logic        e_done [2];
  logic        e_exc [2];
  logic [31:0] e_read [2];
  logic        e_rw;
  logic [1:0]  e_len;
  logic [31:0] e_addr, e_write;
  int          errors = 0;
  int          checks = 0;

  wire [136:0] obs = {m0_gnt, m0_done, m0_read, m0_exc, m1_gnt, m1_done, m1_read, m1_exc,
                      bus_rw, bus_len, bus_addr, bus_write};
  wire [136:0] fp_obs = {fp_m0_gnt, fp_m0_done, fp_m0_read, fp_m0_exc, fp_m1_gnt, fp_m1_done,
                         fp_m1_read, fp_m1_exc, fp_bus_rw, fp_bus_len, fp_bus_addr, fp_bus_write};
  wire [136:0] exp_v = {e_gnt[0], e_done[0], e_read[0], e_exc[0], e_gnt[1], e_done[1], e_read[1],
                        e_exc[1], e_rw, e_len, e_addr, e_write};

  task automatic model_reset();
    owner = -1; just_done = -1; last = 1; edge_no = 0; grant_edge = 0;
    for (int m = 0; m < 2; m++) begin
      e_gnt[m] = 1'b0; e_done[m] = 1'b0; e_exc[m] = 1'b0; e_read[m] = 32'd0;
    end
    e_rw = 1'b0; e_len = 2'd0; e_addr = 32'd0; e_write = 32'd0;
  endtask

  task automatic model_edge();
    int w;
    int prev;
    if (!rst_n) begin
      model_reset();
    end else begin
      edge_no++;
      prev = just_done;
      just_done = -1;
      e_done[0] = 1'b0;
      e_done[1] = 1'b0;
      if (owner >= 0) begin
        if (edge_no - grant_edge == H) begin
          e_read[owner] = e_addr ^ MAGIC;
          e_exc[owner]  = e_addr[31] & e_addr[0];
          e_done[owner] = 1'b1;
          e_gnt[owner]  = 1'b0;
          just_done = owner;
          last = owner;
          owner = -1;
          e_rw = 1'b0; e_len = 2'd0; e_addr = 32'd0; e_write = 32'd0;
        end
      end else begin
        w = -1;
        if (prev >= 0) begin
          if (req[1 - prev]) w = 1 - prev;
        end else if (req[0] && req[1]) w = 1 - last;
        else if (req[0]) w = 0;
        else if (req[1]) w = 1;
        if (w >= 0) begin
          owner = w; grant_edge = edge_no; e_gnt[w] = 1'b1;
          e_rw = rw[w]; e_len = len[w]; e_addr = addr[w]; e_write = wdata[w];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (n) step();
  endtask

  task automatic rst_pulse();
    req[0] = 1'b0;
    req[1] = 1'b0;
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic newfields(int m);
    rw[m]    = 1'($urandom_range(0, 1));
    len[m]   = 2'($urandom_range(0, 3));
    addr[m]  = $urandom;
    wdata[m] = $urandom;
  endtask

  // mode 0: random traffic, 1: both masters request continuously, 2: drop req on done
  task automatic drive(int mode);
    for (int m = 0; m < 2; m++) begin
      if (mode == 1) begin
        req[m] = 1'b1;
        if (e_done[m]) newfields(m);
      end else if (mode == 2) begin
        if (e_done[m]) req[m] = 1'b0;
      end else begin
        if (e_done[m]) begin
          req[m] = 1'($urandom_range(0, 1));
          newfields(m);
        end else if (!req[m]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[m] = 1'b1;
            newfields(m);
          end
        end else if (e_gnt[m]) begin
          if ($urandom_range(0, 9) == 0) req[m] = 1'b0;
          else addr[m] = $urandom;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== 137'd0 || fp_obs !== 137'd0) begin
        errors++;
        $display("FAIL reset: got %h / %h, want all zero", obs, fp_obs);
      end
      checks++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_m0_read();
    int gcnt = 0;
    int dstep = 0;
    req[0] = 1'b1; rw[0] = 1'b0; len[0] = 2'd2; addr[0] = 32'h0000_1000; wdata[0] = 32'd0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL m0_read_model step %0d: got %h want %h", i, obs, exp_v);
      end
      checks++;
      gcnt += int'(m0_gnt);
      if (m0_done && dstep == 0) dstep = i;
      drive(2);
    end
    if (gcnt !== 2) begin errors++; $display("FAIL m0_gnt_cycles: got %0d want 2", gcnt); end
    checks++;
    if (dstep !== 3) begin errors++; $display("FAIL m0_done_latency: got %0d want 3", dstep); end
    checks++;
    if (m0_read !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL m0_read_data: got %h want deadbeef", m0_read);
    end
    checks++;
  endtask

  task automatic test_rr_tie();
    int first_m1 = 0;
    int ndone = 0;
    int prev_d = -1;
    int alt_bad = 0;
    rst_pulse();
    newfields(0); newfields(1);
    req[0] = 1'b1; req[1] = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rr_tie_model step %0d: got %h want %h", i, obs, exp_v);
      end
      checks++;
      if (i == 1) begin
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
          errors++; $display("FAIL rr_tie_first: got gnt %b%b want m0 only", m0_gnt, m1_gnt);
        end
        checks++;
      end
      if (m1_gnt && first_m1 == 0) first_m1 = i;
      if (m0_done || m1_done) begin
        ndone++;
        if (prev_d == int'(m1_done)) alt_bad++;
        prev_d = int'(m1_done);
      end
      drive(1);
    end
    if (first_m1 !== 4) begin errors++; $display("FAIL rr_m1_grant: got step %0d want 4", first_m1); end
    checks++;
    if (alt_bad !== 0 || ndone !== 8) begin
      errors++; $display("FAIL rr_alternate: repeats %0d dones %0d want 0 and 8", alt_bad, ndone);
    end
    checks++;
    idle(6);
  endtask

  task automatic test_fixed_prio();
    int m1g = 0;
    int m0d = 0;
    rst_pulse();
    newfields(0); newfields(1);
    req[0] = 1'b1; req[1] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL fixed_rr_model step %0d: got %h want %h", i, obs, exp_v);
      end
      checks++;
      m1g += int'(fp_m1_gnt);
      m0d += int'(fp_m0_done);
      drive(1);
    end
    if (m1g !== 0 || m0d !== 10) begin
      errors++; $display("FAIL fixed_prio: m1 gnt cycles %0d m0 dones %0d want 0 and 10", m1g, m0d);
    end
    checks++;
    idle(6);
  endtask

  task automatic test_hold_fields();
    idle(4);
    req[1] = 1'b1; rw[1] = 1'b1; len[1] = 2'd3; addr[1] = 32'h0000_2000; wdata[1] = 32'h55;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hold_model step %0d: got %h want %h", i, obs, exp_v);
      end
      checks++;
      if (m1_gnt) begin
        if (bus_addr !== 32'h2000 || bus_rw !== 1'b1 || bus_write !== 32'h55) begin
          errors++; $display("FAIL hold_fields step %0d: got %h rw %b data %h", i, bus_addr, bus_rw, bus_write);
        end
      end else begin
        if (bus_rw !== 1'b0) begin errors++; $display("FAIL hold_rw_idle step %0d: got %b want 0", i, bus_rw); end
      end
      checks++;
      if (i == 1) begin addr[1] = 32'h3000; rw[1] = 1'b0; wdata[1] = 32'hAA; end
      drive(2);
    end
  endtask

  task automatic test_exc();
    int nd = 0;
    idle(4);
    req[0] = 1'b1; rw[0] = 1'b0; len[0] = 2'd1; addr[0] = 32'h8000_0001;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL exc_model step %0d: got %h want %h", i, obs, exp_v);
      end
      checks++;
      if (m0_done) begin
        nd++;
        if (m0_exc !== (nd == 1)) begin
          errors++; $display("FAIL exc_capture done %0d: got %b want %b", nd, m0_exc, nd == 1);
        end
        checks++;
      end
      drive(2);
      if (i == 4) begin req[0] = 1'b1; addr[0] = 32'h0000_1000; end
    end
    if (nd !== 2) begin errors++; $display("FAIL exc_dones: got %0d want 2", nd); end
    checks++;
  endtask

  task automatic test_reset_mid();
    idle(4);
    req[0] = 1'b1; rw[0] = 1'b1; len[0] = 2'd0; addr[0] = 32'h1000; wdata[0] = 32'h1234;
    step();
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got gnt %b want 1", m0_gnt); end
    checks++;
    rst_n = 1'b0;
    model_reset();
    #1;
    if (obs !== 137'd0) begin errors++; $display("FAIL rst_mid_async: got %h want 0", obs); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== 137'd0) begin errors++; $display("FAIL rst_mid_held: got %h want 0", obs); end
      checks++;
    end
    rst_n = 1'b1;
    req[1] = 1'b1; rw[1] = 1'b0; len[1] = 2'd2; addr[1] = 32'h4444; wdata[1] = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) begin
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
          errors++; $display("FAIL rst_tie: got gnt %b%b want m0 only", m0_gnt, m1_gnt);
        end
        checks++;
      end
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rst_after_model step %0d: got %h want %h", i, obs, exp_v);
      end
      checks++;
      drive(2);
    end
  endtask

  task automatic test_random();
    idle(4);
    for (int i = 1; i <= 600; i++) begin
      step();
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random step %0d: got %h want %h", i, obs, exp_v);
      end
      checks++;
      drive(0);
    end
    idle(6);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; rw[m] = 1'b0; len[m] = 2'd0; addr[m] = 32'd0; wdata[m] = 32'd0;
    end
    model_reset();
    test_reset();
    test_m0_read();
    test_rr_tie();
    test_fixed_prio();
    test_hold_fields();
    test_exc();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
